// File: rtl/mult_share_scan_ctrl.sv
// rtl/mult_share_scan_ctrl.sv - shared 2-bit multiplier with round-robin arbitration and 4-digit scan display
module mult_share_scan_ctrl #(
    parameter int SCAN_DIV = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req_valid,
    input  logic [7:0] req_a,
    input  logic [7:0] req_b,
    output logic [3:0] req_ready,
    output logic [1:0] mult_a,
    output logic [1:0] mult_b,
    input  logic [3:0] mult_q,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [1:0] rsp_id,
    output logic [3:0] rsp_q,
    output logic [3:0] digit,
    output logic [3:0] anodes
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]          state;
    logic [1:0]          last_grant;
    logic [1:0]          id;
    logic [1:0]          grant_id;
    logic                grant_hit;
    logic [1:0]          idx;
    logic [3:0]          slot [4];
    logic [SCAN_DIV+1:0] scan_cnt;
    logic [1:0]          k;
    logic                capture;

    assign k       = scan_cnt[SCAN_DIV+1:SCAN_DIV];
    assign capture = (state == CALC);

    // Round-robin pick: search starts just after the previous winner, so it has lowest priority
    always_comb begin
        grant_id  = last_grant;
        grant_hit = 1'b0;
        idx       = last_grant;
        for (int j = 0; j < 4; j++) begin
            idx = last_grant + 2'(j + 1);
            if (!grant_hit && req_valid[idx]) begin
                grant_hit = 1'b1;
                grant_id  = idx;
            end
        end
        req_ready = 4'b0000;
        if (state == IDLE && grant_hit) begin
            req_ready = 4'b0001 << grant_id;
        end
    end

    // Operation sequencer: latch operands on grant, capture product, hold response until accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 2'd3;
            id         <= 2'd0;
            mult_a     <= 2'd0;
            mult_b     <= 2'd0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 2'd0;
            rsp_q      <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_hit) begin
                        mult_a     <= req_a[{grant_id, 1'b0} +: 2];
                        mult_b     <= req_b[{grant_id, 1'b0} +: 2];
                        id         <= grant_id;
                        last_grant <= grant_id;
                        state      <= CALC;
                    end
                end
                CALC: begin
                    rsp_q     <= mult_q;
                    rsp_id    <= id;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Per-requester product store feeding the display
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < 4; s++) slot[s] <= 4'd0;
        end else if (capture) begin
            slot[id] <= mult_q;
        end
    end

    // Free-running scan; digit and anode registered together, fresh capture bypassed to the active digit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            anodes   <= 4'b1110;
            digit    <= 4'd0;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
            anodes   <= ~(4'b0001 << k);
            digit    <= (capture && id == k) ? mult_q : slot[k];
        end
    end

endmodule

// File: tb/tb_mult_share_scan_ctrl.sv
// tb/tb_mult_share_scan_ctrl.sv - directed self-checking bench for mult_share_scan_ctrl
module tb_mult_share_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req_valid = 4'b0;
    logic [7:0] req_a = 8'h0;
    logic [7:0] req_b = 8'h0;
    logic [3:0] req_ready;
    logic [1:0] mult_a;
    logic [1:0] mult_b;
    logic [3:0] mult_q;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [1:0] rsp_id;
    logic [3:0] rsp_q;
    logic [3:0] digit;
    logic [3:0] anodes;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign mult_q = {2'b00, mult_a} * {2'b00, mult_b};

    mult_share_scan_ctrl #(.SCAN_DIV(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .mult_a(mult_a), .mult_b(mult_b), .mult_q(mult_q),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_q(rsp_q),
        .digit(digit), .anodes(anodes)
    );

    task automatic do_reset();
        req_valid = 4'b0;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if (req_ready !== 4'b0 || rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_q !== 4'd0) begin
            failures++;
            $display("FAIL reset_rsp got ready=%b valid=%b id=%0d q=%0d want 0000/0/0/0", req_ready, rsp_valid, rsp_id, rsp_q);
        end
        @(negedge clk);
        checks++;
        if (mult_a !== 2'd0 || mult_b !== 2'd0 || anodes !== 4'b1110 || digit !== 4'd0) begin
            failures++;
            $display("FAIL reset_disp got a=%0d b=%0d anodes=%b digit=%0d want 0/0/1110/0", mult_a, mult_b, anodes, digit);
        end
        do_reset();
    endtask

    task automatic test_single_op();
        req_valid = 4'b0001; req_a = 8'h03; req_b = 8'h03; rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++; $display("FAIL single_grant got %b want 0001", req_ready);
        end
        @(negedge clk);
        req_valid = 4'b0;
        checks++;
        if (mult_a !== 2'd3 || mult_b !== 2'd3 || req_ready !== 4'b0 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_calc got a=%0d b=%0d ready=%b valid=%b want 3/3/0000/0", mult_a, mult_b, req_ready, rsp_valid);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_q !== 4'd9) begin
            failures++;
            $display("FAIL single_rsp got valid=%b id=%0d q=%0d want 1/0/9", rsp_valid, rsp_id, rsp_q);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin
            failures++; $display("FAIL single_done got valid=%b want 0", rsp_valid);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] want_id;
        do_reset();
        req_valid = 4'b1111; req_a = 8'he4; req_b = 8'he4; rsp_ready = 1'b1;
        #1;
        for (int n = 0; n < 5; n++) begin
            want_id = 2'(n);
            checks++;
            if (req_ready !== (4'b0001 << want_id)) begin
                failures++; $display("FAIL rr_grant op%0d got %b want %b", n, req_ready, 4'b0001 << want_id);
            end
            @(negedge clk);
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== want_id || rsp_q !== 4'(want_id * want_id)) begin
                failures++;
                $display("FAIL rr_rsp op%0d got valid=%b id=%0d q=%0d want 1/%0d/%0d", n, rsp_valid, rsp_id, rsp_q, want_id, want_id * want_id);
            end
            @(negedge clk);
            #1;
        end
        req_valid = 4'b0;
    endtask

    task automatic test_backpressure();
        req_valid = 4'b0100; req_a = 8'h20; req_b = 8'h30; rsp_ready = 1'b0;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            failures++; $display("FAIL bp_grant got %b want 0100", req_ready);
        end
        @(negedge clk);
        @(negedge clk);
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_q !== 4'd6 || rsp_id !== 2'd2 || req_ready !== 4'b0) begin
                failures++;
                $display("FAIL bp_hold cyc%0d got valid=%b q=%0d id=%0d ready=%b want 1/6/2/0000", c, rsp_valid, rsp_q, rsp_id, req_ready);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        req_valid = 4'b0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin
            failures++; $display("FAIL bp_release got valid=%b want 0", rsp_valid);
        end
        req_valid = 4'b0100; req_a = 8'h30; req_b = 8'h10;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            failures++; $display("FAIL bp_idle got %b want 0100", req_ready);
        end
        req_valid = 4'b0;
        @(negedge clk);
        checks++;
        if (mult_a !== 2'd2 || mult_b !== 2'd3 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL drop_nolatch got a=%0d b=%0d valid=%b want 2/3/0", mult_a, mult_b, rsp_valid);
        end
    endtask

    task automatic preset_op(input logic [1:0] rid, input logic [1:0] a, input logic [1:0] b);
        req_valid = 4'b0001 << rid;
        req_a = 8'(a) << {rid, 1'b0};
        req_b = 8'(b) << {rid, 1'b0};
        @(negedge clk);
        req_valid = 4'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_display();
        logic [3:0] prev;
        logic       synced;
        int         ph;
        do_reset();
        rsp_ready = 1'b1;
        preset_op(2'd0, 2'd1, 2'd1);
        preset_op(2'd1, 2'd1, 2'd2);
        preset_op(2'd2, 2'd1, 2'd3);
        preset_op(2'd3, 2'd2, 2'd2);
        synced = 1'b0;
        for (int c = 0; c < 40 && !synced; c++) begin
            prev = anodes;
            @(negedge clk);
            if (prev === 4'b0111 && anodes === 4'b1110) synced = 1'b1;
        end
        checks++;
        if (!synced) begin
            failures++; $display("FAIL disp_sync got anodes=%b want wrap 0111->1110 within 40 cycles", anodes);
        end
        for (int c = 0; c < 20; c++) begin
            ph = (c / 4) % 4;
            checks++;
            if (anodes !== ~(4'b0001 << ph) || digit !== 4'(ph + 1)) begin
                failures++;
                $display("FAIL disp_scan cyc%0d got anodes=%b digit=%0d want %b/%0d", c, anodes, digit, ~(4'b0001 << ph), ph + 1);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        rsp_ready = 1'b1;
        preset_op(2'd0, 2'd3, 2'd3);
        req_valid = 4'b0010; req_a = 8'h04; req_b = 8'h0c;
        @(negedge clk);
        req_valid = 4'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_q !== 4'd0 || mult_a !== 2'd0 || mult_b !== 2'd0 || anodes !== 4'b1110 || digit !== 4'd0) begin
            failures++;
            $display("FAIL midrst_async got valid=%b q=%0d a=%0d b=%0d anodes=%b digit=%0d want 0/0/0/0/1110/0", rsp_valid, rsp_q, mult_a, mult_b, anodes, digit);
        end
        @(negedge clk);
        @(negedge clk);
        req_valid = 4'b0011;
        rst_n = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0001 || rsp_valid !== 1'b0) begin
            failures++; $display("FAIL midrst_prio got ready=%b valid=%b want 0001/0", req_ready, rsp_valid);
        end
        req_valid = 4'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || digit !== 4'd0) begin
            failures++; $display("FAIL midrst_lost got valid=%b digit=%0d want 0/0", rsp_valid, digit);
        end
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_round_robin();
        test_backpressure();
        test_display();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
